// File: rtl/fifo_pkg.sv
// Shared FIFO defaults and the read-side packer state encoding.
// fifo_top and fifo_rd_packer must agree on the entry width, so both take it from here.
package fifo_pkg;

   localparam int DEF_DATA_SIZE = 4;
   localparam int DEF_ADDR_SIZE = 4;
   localparam int DEF_PACK_CNT  = 4;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      EMIT  = 2'd2
   } pack_state_e;

endpackage

// File: rtl/fifo_rd_accum.sv
// Slot-indexed accumulator for the read-side packer.
// Entries land at slot cnt; the merged view carries the entry landing this cycle.
module fifo_rd_accum
   import fifo_pkg::*;
#(
   parameter int DATA_SIZE = DEF_DATA_SIZE,
   parameter int PACK_CNT  = DEF_PACK_CNT,
   parameter int CNT_W     = $clog2(PACK_CNT + 1)
) (
   input  logic                          rd_clk,
   input  logic                          rd_rst,
   input  logic                          wr_en,
   input  logic [DATA_SIZE-1:0]          wr_data,
   input  logic                          drain,
   output logic [CNT_W-1:0]              cnt,
   output logic                          complete,
   output logic [DATA_SIZE*PACK_CNT-1:0] word
);

   localparam int SLOT_W = (PACK_CNT > 1) ? $clog2(PACK_CNT) : 1;

   logic [PACK_CNT-1:0][DATA_SIZE-1:0] slots;
   logic [PACK_CNT-1:0][DATA_SIZE-1:0] merged;
   logic [SLOT_W-1:0]                  slot;

   // cnt never exceeds PACK_CNT-1, so its low bits always address a real slot.
   assign slot     = cnt[SLOT_W-1:0];
   assign complete = wr_en && (cnt == CNT_W'(PACK_CNT - 1));
   assign word     = merged;

   // NOTE: merged gets a full default before the conditional write, so no latch is inferred.
   always_comb begin
      merged = slots;
      if (wr_en) merged[slot] = wr_data;
   end

   // NOTE: the accumulator is a handful of flops, not a RAM, so it is reset; cleared
   // slots are also what zero-fills a flushed partial word.
   always_ff @(posedge rd_clk or negedge rd_rst) begin
      if (!rd_rst) begin
         slots <= '0;
         cnt   <= '0;
      end else if (complete || drain) begin
         slots <= '0;
         cnt   <= '0;
      end else if (wr_en) begin
         // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
         slots[slot] <= wr_data;
         cnt         <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/fifo_rd_packer.sv
// Pops DATA_SIZE entries from fifo_top and packs PACK_CNT of them into one wide
// valid/ready word; flush emits a zero-padded partial word.
module fifo_rd_packer
   import fifo_pkg::*;
#(
   parameter int DATA_SIZE = DEF_DATA_SIZE,
   parameter int PACK_CNT  = DEF_PACK_CNT,
   parameter int CNT_W     = $clog2(PACK_CNT + 1)
) (
   input  logic                          rd_clk,
   input  logic                          rd_rst,
   input  logic                          fifo_empty,
   output logic                          fifo_rd_en,
   input  logic [DATA_SIZE-1:0]          fifo_rd_data,
   input  logic                          flush,
   output logic [DATA_SIZE*PACK_CNT-1:0] out_data,
   output logic [CNT_W-1:0]              out_count,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          flush_done
);

   localparam int WORD_W = DATA_SIZE * PACK_CNT;

   pack_state_e       state;
   pack_state_e       state_next;
   logic              inflight;
   logic [CNT_W-1:0]  cnt;
   logic              complete;
   logic [WORD_W-1:0] word;
   logic              out_free;
   logic              credit_ok;
   logic              emit_load;
   logic              done_set;

   fifo_rd_accum #(
      .DATA_SIZE (DATA_SIZE),
      .PACK_CNT  (PACK_CNT),
      .CNT_W     (CNT_W)
   ) u_accum (
      .rd_clk   (rd_clk),
      .rd_rst   (rd_rst),
      .wr_en    (inflight),
      .wr_data  (fifo_rd_data),
      .drain    (emit_load),
      .cnt      (cnt),
      .complete (complete),
      .word     (word)
   );

   assign out_free = !out_valid || out_ready;

   // Only the read that would complete a word needs the output register to be free.
   assign credit_ok = ((int'(cnt) + int'(inflight)) < (PACK_CNT - 1)) || out_free;

   always_ff @(posedge rd_clk or negedge rd_rst) begin
      if (!rd_rst) state <= RUN;
      else         state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         RUN:     if (flush) state_next = DRAIN;
         DRAIN:   if (!inflight) state_next = (cnt == '0) ? RUN : EMIT;
         EMIT:    if (out_free) state_next = RUN;
         default: state_next = RUN;
      endcase
   end

   always_comb begin
      fifo_rd_en = 1'b0;
      emit_load  = 1'b0;
      done_set   = 1'b0;
      unique case (state)
         // rd_rst gates the request so fifo_top never sees a pop while we are held in reset.
         RUN:     fifo_rd_en = rd_rst && !flush && !fifo_empty && credit_ok;
         DRAIN:   done_set   = !inflight && (cnt == '0);
         EMIT: begin
            emit_load = out_free;
            done_set  = out_free;
         end
         default: ;
      endcase
   end

   always_ff @(posedge rd_clk or negedge rd_rst) begin
      if (!rd_rst) inflight <= 1'b0;
      else         inflight <= fifo_rd_en && !fifo_empty;
   end

   always_ff @(posedge rd_clk or negedge rd_rst) begin
      if (!rd_rst) begin
         out_data   <= '0;
         out_count  <= '0;
         out_valid  <= 1'b0;
         flush_done <= 1'b0;
      end else begin
         flush_done <= done_set;
         if (complete) begin
            out_data  <= word;
            out_count <= CNT_W'(PACK_CNT);
            out_valid <= 1'b1;
         end else if (emit_load) begin
            out_data  <= word;
            out_count <= cnt;
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer: FIFO read-port model plus a scoreboard of expected words.
module tb_fifo_rd_packer;
   import fifo_pkg::*;

   localparam int DW = 4;
   localparam int PC = 4;
   localparam int CW = $clog2(PC + 1);
   localparam int WW = DW * PC;

   typedef struct packed {
      logic [WW-1:0] data;
      logic [CW-1:0] count;
   } word_t;

   logic          rd_clk = 1'b0;
   logic          rd_rst = 1'b0;
   logic          fifo_empty = 1'b1;
   logic          fifo_rd_en;
   logic [DW-1:0] fifo_rd_data = '0;
   logic          flush = 1'b0;
   logic [WW-1:0] out_data;
   logic [CW-1:0] out_count;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic          flush_done;

   logic [DW-1:0] fifo_q[$];
   word_t         exp_q[$];

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int acc_total = 0;
   int last_acc_cyc = 0;
   int cur_run = 0;
   int max_run = 0;
   int rd_while_empty = 0;
   int valid_cycles = 0;
   int first_valid_cyc = 0;
   int fd_count = 0;
   int fd_cyc = 0;
   bit prev_valid = 1'b0;
   bit toggle_mode = 1'b0;
   bit phase = 1'b0;
   bit accept = 1'b0;

   fifo_rd_packer #(
      .DATA_SIZE (DW),
      .PACK_CNT  (PC),
      .CNT_W     (CW)
   ) dut (
      .rd_clk       (rd_clk),
      .rd_rst       (rd_rst),
      .fifo_empty   (fifo_empty),
      .fifo_rd_en   (fifo_rd_en),
      .fifo_rd_data (fifo_rd_data),
      .flush        (flush),
      .out_data     (out_data),
      .out_count    (out_count),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .flush_done   (flush_done)
   );

   always #5 rd_clk = ~rd_clk;

   always @(posedge rd_clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      assert (observed === expected) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge rd_clk);
      #1;
   endtask

   // Queue entries base..base+n-1 and the full words they should assemble into.
   task automatic load_entries(input int base, input int n);
      word_t w;
      int    k;
      w = '0;
      k = 0;
      for (int i = 0; i < n; i++) begin
         logic [DW-1:0] v;
         v = DW'(base + i);
         fifo_q.push_back(v);
         w.data[k*DW +: DW] = v;
         k++;
         if (k == PC) begin
            w.count = CW'(PC);
            exp_q.push_back(w);
            w = '0;
            k = 0;
         end
      end
   endtask

   task automatic wait_drain(input string tag);
      int k = 0;
      while ((fifo_q.size() != 0 || exp_q.size() != 0) && k < 300) begin
         step(1);
         k++;
      end
      step(4);
      check(tag, k < 300, 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rd_en"},      fifo_rd_en, 0);
      check({tag, "_out_data"},   out_data,   0);
      check({tag, "_out_count"},  out_count,  0);
      check({tag, "_out_valid"},  out_valid,  0);
      check({tag, "_flush_done"}, flush_done, 0);
   endtask

   // FIFO read port: an accepted pop returns its entry one cycle later.
   always begin
      @(negedge rd_clk);
      accept = fifo_rd_en && !fifo_empty;
      if (fifo_rd_en && fifo_empty) rd_while_empty++;
      if (accept) begin
         acc_total++;
         last_acc_cyc = cyc;
         cur_run++;
         if (cur_run > max_run) max_run = cur_run;
      end else begin
         cur_run = 0;
      end
      @(posedge rd_clk);
      #1;
      if (accept && fifo_q.size() != 0) fifo_rd_data = fifo_q.pop_front();
      phase      = ~phase;
      fifo_empty = (fifo_q.size() == 0) || (toggle_mode && phase);
   end

   // Output monitor: every valid cycle must show the scoreboard head; pop on transfer.
   always @(negedge rd_clk) begin
      if (out_valid) begin
         valid_cycles++;
         if (!prev_valid) first_valid_cyc = cyc;
         check("sb_has_word", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            check("word_data",  out_data,  exp_q[0].data);
            check("word_count", out_count, exp_q[0].count);
            if (out_ready) void'(exp_q.pop_front());
         end
      end
      prev_valid = out_valid;
      if (flush_done) begin
         fd_count++;
         fd_cyc = cyc;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int    acc_base;
      int    fd_base;
      int    fcyc;
      int    k;
      word_t w;

      step(3);
      check_reset_outputs("reset");
      rd_rst = 1'b1;
      step(2);

      // Single word, consumer always ready.
      out_ready    = 1'b1;
      valid_cycles = 0;
      load_entries(1, 4);
      wait_drain("t1_drain");
      check("t1_valid_len", valid_cycles, 1);
      check("t1_latency", first_valid_cyc - last_acc_cyc, 2);

      // Eight preloaded entries stream back to back.
      max_run  = 0;
      acc_base = acc_total;
      load_entries(1, 8);
      wait_drain("t2_drain");
      check("t2_run", max_run, 8);
      check("t2_reads", acc_total - acc_base, 8);

      // Stalled consumer: the credit rule stops after the 7th read.
      out_ready = 1'b0;
      acc_base  = acc_total;
      load_entries(1, 8);
      step(20);
      check("t3_reads_stalled", acc_total - acc_base, 7);
      check("t3_out_valid", out_valid, 1);
      out_ready = 1'b1;
      wait_drain("t3_drain");
      check("t3_reads_total", acc_total - acc_base, 8);

      // Partial word flush.
      fifo_q.push_back(4'h5);
      fifo_q.push_back(4'h6);
      w.data  = 16'h0065;
      w.count = 3'd2;
      exp_q.push_back(w);
      step(6);
      fd_base      = fd_count;
      valid_cycles = 0;
      flush        = 1'b1;
      fcyc         = cyc;
      step(1);
      flush = 1'b0;
      k = 0;
      while (fd_count == fd_base && k < 40) begin
         step(1);
         k++;
      end
      step(3);
      check("t4_done_pulses", fd_count - fd_base, 1);
      check("t4_word_seen", valid_cycles, 1);
      check("t4_done_after_word", fd_cyc >= first_valid_cyc, 1);
      check("t4_done_latency", fd_cyc - fcyc >= 2, 1);
      check("t4_sb_empty", exp_q.size(), 0);

      // Flush with an empty accumulator.
      fd_base      = fd_count;
      valid_cycles = 0;
      flush        = 1'b1;
      fcyc         = cyc;
      step(1);
      flush = 1'b0;
      step(6);
      check("t4e_done_pulses", fd_count - fd_base, 1);
      check("t4e_no_word", valid_cycles, 0);
      check("t4e_done_latency", fd_cyc - fcyc, 2);

      // Empty flag toggling every cycle.
      toggle_mode    = 1'b1;
      rd_while_empty = 0;
      acc_base       = acc_total;
      load_entries(9, 8);
      wait_drain("t5_drain");
      toggle_mode = 1'b0;
      check("t5_no_rd_while_empty", rd_while_empty, 0);
      check("t5_reads", acc_total - acc_base, 8);

      // Reset with two entries already popped.
      acc_base = acc_total;
      fifo_q.push_back(4'hA);
      fifo_q.push_back(4'hB);
      k = 0;
      while (acc_total - acc_base < 2 && k < 40) begin
         step(1);
         k++;
      end
      check("t6_popped_two", acc_total - acc_base, 2);
      step(1);
      rd_rst = 1'b0;
      #1;
      check_reset_outputs("t6_reset");
      step(2);
      rd_rst       = 1'b1;
      step(1);
      valid_cycles = 0;
      load_entries(1, 4);
      wait_drain("t6_drain");
      check("t6_valid_len", valid_cycles, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
